// File: rtl/boot_loader_ckd_if.sv
// Boot ROM read port and instruction memory write port shared by the boot loader
// (master) and the memories it drives (slave).
interface boot_loader_ckd_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20
);
    logic                  boot_mem_rd_en;
    logic [ADDR_WIDTH-1:0] boot_mem_addr;
    logic [DATA_WIDTH-1:0] boot_mem_rd_data;
    logic                  inst_mem_wr_en;
    logic [ADDR_WIDTH-1:0] inst_mem_addr;
    logic [DATA_WIDTH-1:0] inst_mem_wr_data;

    modport master (
        output boot_mem_rd_en, boot_mem_addr,
        input  boot_mem_rd_data,
        output inst_mem_wr_en, inst_mem_addr, inst_mem_wr_data
    );

    modport slave (
        input  boot_mem_rd_en, boot_mem_addr,
        output boot_mem_rd_data,
        input  inst_mem_wr_en, inst_mem_addr, inst_mem_wr_data
    );
endinterface

// File: rtl/boot_loader_ckd.sv
// Copies a magic/length/payload/checksum image from boot ROM into instruction
// memory, validating each field, then releases the processor.
module boot_loader_ckd #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 20,
    parameter int                    ROM_LATENCY = 1,
    parameter int                    DEST_BASE   = 0,
    parameter logic [DATA_WIDTH-1:0] MAGIC       = 32'hB007_1DC5,
    parameter int                    MAX_WORDS   = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    output logic                boot_mode,
    output logic                boot_done,
    output logic                boot_err,
    output logic [1:0]          err_code,
    boot_loader_ckd_if.master   mem
);
    typedef enum logic [2:0] {
        S_MAGIC, S_LEN, S_COPY, S_SUM, S_DONE, S_ERR
    } state_t;

    localparam logic [2:0]            LAT   = ROM_LATENCY[2:0];
    localparam logic [ADDR_WIDTH:0]   MAX_W = (ADDR_WIDTH+1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(DEST_BASE);

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [2:0]            lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;

    logic                  reading;
    logic                  sample;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] len_w;

    assign len_w   = mem.boot_mem_rd_data[ADDR_WIDTH-1:0];
    assign reading = (state_q == S_MAGIC) || (state_q == S_LEN) ||
                     (state_q == S_COPY)  || (state_q == S_SUM);
    // ROM data for the word in flight is valid while lat_q reaches the latency.
    assign sample  = reading && pend_q && (lat_q == LAT);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        lat_d     = lat_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mode_d    = mode_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;
        issue     = 1'b0;

        if (reading) begin
            if (!pend_q) begin
                issue = 1'b1;
            end else if (!sample) begin
                lat_d = lat_q + 3'd1;
            end
        end

        if (sample) begin
            ptr_d  = ptr_q + 1'b1;
            pend_d = 1'b0;
            case (state_q)
                S_MAGIC: begin
                    if (mem.boot_mem_rd_data != MAGIC) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        state_d = S_LEN;
                        issue   = 1'b1;
                    end
                end
                S_LEN: begin
                    if ((len_w == '0) || ({1'b0, len_w} > MAX_W)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end else begin
                        len_d   = len_w;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = S_COPY;
                        issue   = 1'b1;
                    end
                end
                S_COPY: begin
                    acc_d     = acc_q + mem.boot_mem_rd_data;
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE + idx_q;
                    wr_data_d = mem.boot_mem_rd_data;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_d = S_SUM;
                    end
                    issue = 1'b1;
                end
                S_SUM: begin
                    if (mem.boot_mem_rd_data == acc_q) begin
                        state_d = S_DONE;
                        mode_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                    end
                end
                default: ;
            endcase
        end

        if (((state_q == S_DONE) || (state_q == S_ERR)) && restart) begin
            state_d = S_MAGIC;
            ptr_d   = '0;
            pend_d  = 1'b0;
            mode_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = 2'd0;
        end

        // A new read starts the same cycle the previous word is consumed.
        if (issue) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_d;
            pend_d    = 1'b1;
            lat_d     = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_MAGIC;
            pend_q    <= 1'b0;
            lat_q     <= 3'd0;
            ptr_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            mode_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            lat_q     <= lat_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign mem.boot_mem_rd_en   = rd_en_q;
    assign mem.boot_mem_addr    = rd_addr_q;
    assign mem.inst_mem_wr_en   = wr_en_q;
    assign mem.inst_mem_addr    = wr_addr_q;
    assign mem.inst_mem_wr_data = wr_data_q;
    assign boot_mode            = mode_q;
    assign boot_done            = done_q;
    assign boot_err             = err_q;
    assign err_code             = code_q;
endmodule

// File: tb/tb_boot_loader_ckd.sv
// Scoreboard bench: two loaders (latency 1 / base 0 and latency 3 / base 0x100)
// against behavioural ROM models; expected writes are queued and popped on wr_en.
module tb_boot_loader_ckd;
    localparam logic [31:0] MAGIC_W = 32'hB007_1DC5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0, rst_b_n = 1'b0;
    logic restart_a = 1'b0, restart_b = 1'b0;
    logic mode_a, done_a, err_a, mode_b, done_b, err_b;
    logic [1:0] code_a, code_b;

    boot_loader_ckd_if #(.DATA_WIDTH(32), .ADDR_WIDTH(20)) ifa ();
    boot_loader_ckd_if #(.DATA_WIDTH(32), .ADDR_WIDTH(20)) ifb ();

    boot_loader_ckd #(.ROM_LATENCY(1), .DEST_BASE(0)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .restart(restart_a), .boot_mode(mode_a),
        .boot_done(done_a), .boot_err(err_a), .err_code(code_a), .mem(ifa));

    boot_loader_ckd #(.ROM_LATENCY(3), .DEST_BASE(32'h100)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .restart(restart_b), .boot_mode(mode_b),
        .boot_done(done_b), .boot_err(err_b), .err_code(code_b), .mem(ifb));

    logic [31:0] rom_a [0:15];
    logic [31:0] rom_b [0:15];
    logic [31:0] pipe_b [0:2];
    logic [31:0] pay [4];
    logic [51:0] exp_a [$];
    logic [51:0] exp_b [$];

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int rd_cnt_a = 0, wr_cnt_a = 0, rd_cnt_b = 0, wr_cnt_b = 0, last_rd_b = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM models: stale data is replaced by a marker so early or late sampling shows up.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ifa.boot_mem_rd_data <= ifa.boot_mem_rd_en ? rom_a[ifa.boot_mem_addr[3:0]] : 32'hDEAD_0000;
        pipe_b[0] <= ifb.boot_mem_rd_en ? rom_b[ifb.boot_mem_addr[3:0]] : 32'hDEAD_0001;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign ifb.boot_mem_rd_data = pipe_b[2];

    always @(negedge clk) begin
        if (rst_a_n && ifa.boot_mem_rd_en) begin
            if (rd_cnt_a == 0) check("a_first_rd_addr", ifa.boot_mem_addr, 0);
            rd_cnt_a++;
        end
        if (rst_a_n && ifa.inst_mem_wr_en) begin
            $display("A write addr=%0h data=%0h", ifa.inst_mem_addr, ifa.inst_mem_wr_data);
            wr_cnt_a++;
            if (exp_a.size() == 0) check("a_wr_unexpected", 1, 0);
            else begin
                logic [51:0] e;
                e = exp_a.pop_front();
                check("a_wr_addr", ifa.inst_mem_addr, e[51:32]);
                check("a_wr_data", ifa.inst_mem_wr_data, e[31:0]);
            end
        end
        if (rst_b_n && ifb.boot_mem_rd_en) begin
            check("b_rd_addr", ifb.boot_mem_addr, rd_cnt_b);
            if (last_rd_b >= 0) check("b_rd_gap", cyc - last_rd_b, 4);
            last_rd_b = cyc;
            rd_cnt_b++;
        end
        if (rst_b_n && ifb.inst_mem_wr_en) begin
            $display("B write addr=%0h data=%0h", ifb.inst_mem_addr, ifb.inst_mem_wr_data);
            wr_cnt_b++;
            if (exp_b.size() == 0) check("b_wr_unexpected", 1, 0);
            else begin
                logic [51:0] e;
                e = exp_b.pop_front();
                check("b_wr_addr", ifb.inst_mem_addr, e[51:32]);
                check("b_wr_data", ifb.inst_mem_wr_data, e[31:0]);
            end
        end
    end

    task automatic image_a(input logic [31:0] magic, input logic [31:0] len, input logic [31:0] sum);
        rom_a[0] = magic;
        rom_a[1] = len;
        for (int i = 0; i < 4; i++) rom_a[2+i] = pay[i];
        rom_a[6] = sum;
    endtask

    task automatic push_a();
        for (int i = 0; i < 4; i++) exp_a.push_back({20'(i), pay[i]});
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_mode"}, mode_a, 1);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_err"}, err_a, 0);
        check({tag, "_code"}, code_a, 0);
        check({tag, "_rd_en"}, ifa.boot_mem_rd_en, 0);
        check({tag, "_wr_en"}, ifa.inst_mem_wr_en, 0);
        check({tag, "_addr"}, ifa.boot_mem_addr, 0);
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a_n = 1'b0;
        #1 check_reset_a("a_rst");
        @(negedge clk);
        rd_cnt_a = 0;
        wr_cnt_a = 0;
        rst_a_n = 1'b1;
    endtask

    // Counts rising edges until done or err appears; edge 1 is the first after the call.
    task automatic wait_a(input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            @(posedge clk);
            edges++;
            #1;
            if (done_a || err_a) break;
        end
        if (!(done_a || err_a)) check("a_timeout", 0, 1);
    endtask

    initial begin
        int edges;
        logic [31:0] sum_b;
        pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h33; pay[3] = 32'h44;
        for (int i = 0; i < 16; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
        for (int i = 0; i < 3; i++) pipe_b[i] = '0;

        // Nominal load
        image_a(MAGIC_W, 4, 32'hAA);
        push_a();
        reset_a();
        wait_a(100, edges);
        $display("nominal: finished at edge %0d", edges);
        check("nom_edges", edges, 15);
        check("nom_done", done_a, 1);
        check("nom_mode", mode_a, 0);
        check("nom_err", err_a, 0);
        check("nom_wr_cnt", wr_cnt_a, 4);
        check("nom_queue", exp_a.size(), 0);

        // Bad magic
        image_a(32'hDEAD_BEEF, 4, 32'hAA);
        reset_a();
        wait_a(100, edges);
        check("magic_edges", edges, 3);
        check("magic_err", err_a, 1);
        check("magic_code", code_a, 1);
        check("magic_mode", mode_a, 1);
        repeat (5) @(negedge clk);
        check("magic_rd_cnt", rd_cnt_a, 1);
        check("magic_wr_cnt", wr_cnt_a, 0);

        // Bad length: zero and one past the maximum
        for (int k = 0; k < 2; k++) begin
            image_a(MAGIC_W, (k == 0) ? 32'd0 : 32'd4097, 32'hAA);
            reset_a();
            wait_a(100, edges);
            check("len_edges", edges, 5);
            check("len_err", err_a, 1);
            check("len_code", code_a, 2);
            repeat (5) @(negedge clk);
            check("len_rd_cnt", rd_cnt_a, 2);
            check("len_wr_cnt", wr_cnt_a, 0);
        end

        // Checksum mismatch, then restart with corrected ROM
        image_a(MAGIC_W, 4, 32'hAB);
        push_a();
        reset_a();
        wait_a(100, edges);
        check("sum_edges", edges, 15);
        check("sum_err", err_a, 1);
        check("sum_code", code_a, 3);
        check("sum_mode", mode_a, 1);
        check("sum_wr_cnt", wr_cnt_a, 4);
        rom_a[6] = 32'hAA;
        push_a();
        @(negedge clk);
        rd_cnt_a = 0;
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        check("rst_err_clr", err_a, 0);
        check("rst_code_clr", code_a, 0);
        check("rst_mode", mode_a, 1);
        wait_a(100, edges);
        check("restart_edges", edges, 15);
        check("restart_done", done_a, 1);
        check("restart_queue", exp_a.size(), 0);

        // Asynchronous reset while payload word 2 is in flight
        image_a(MAGIC_W, 4, 32'hAA);
        push_a();
        reset_a();
        repeat (10) @(posedge clk);
        #2 rst_a_n = 1'b0;
        #1 check_reset_a("a_midrst");
        check("midrst_wr_cnt", wr_cnt_a, 2);
        exp_a.delete();
        push_a();
        @(negedge clk);
        rd_cnt_a = 0;
        wr_cnt_a = 0;
        rst_a_n = 1'b1;
        wait_a(100, edges);
        check("reload_edges", edges, 15);
        check("reload_done", done_a, 1);
        check("reload_wr_cnt", wr_cnt_a, 4);

        // Latency 3, base 0x100, two payload words
        rom_b[0] = MAGIC_W;
        rom_b[1] = 32'd2;
        rom_b[2] = 32'h1234_5678;
        rom_b[3] = 32'h0BAD_F00D;
        sum_b = rom_b[2] + rom_b[3];
        rom_b[4] = sum_b;
        exp_b.push_back({20'h100, rom_b[2]});
        exp_b.push_back({20'h101, rom_b[3]});
        @(negedge clk);
        rst_b_n = 1'b1;
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (done_b || err_b) break;
        end
        if (!(done_b || err_b)) check("b_timeout", 0, 1);
        check("b_edges", edges, 21);
        check("b_done", done_b, 1);
        check("b_mode", mode_b, 0);
        check("b_err", err_b, 0);
        check("b_wr_cnt", wr_cnt_b, 2);
        check("b_rd_cnt", rd_cnt_b, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
